// File: rtl/spi_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_core_pkg
// Purpose  : Shared FSM state encoding and default sizing for the SPI sender.
// Revision : 1.0 - initial release
// ============================================================================
package spi_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } spi_state_t;

    localparam int c_DEF_DATA_W  = 8;
    localparam int c_DEF_CLK_DIV = 50;

endpackage : spi_core_pkg
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_div
// Purpose  : Half-period tick generator; one-cycle tick every CLK_DIV enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_div
    import spi_core_pkg::*;
#(
    parameter int CLK_DIV = c_DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Held at zero while disabled so every enabled stretch starts a fresh half-period.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == c_LAST);

endmodule : spi_clk_div
`default_nettype wire

// File: rtl/spi_send_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_send_ctrl
// Purpose  : Wrapping event counter whose value is sent on request as a mode-0 SPI frame.
// Revision : 1.0 - initial release
// ============================================================================
module spi_send_ctrl
    import spi_core_pkg::*;
#(
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int CLK_DIV = c_DEF_CLK_DIV
) (
    input  logic              clk_100,
    input  logic              s_rst,
    input  logic              next_count_i,
    input  logic              start_send_i,
    output logic [DATA_W-1:0] count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              spi_cs_n_o,
    output logic              spi_sclk_o,
    output logic              spi_mosi_o
);

    localparam int                 c_BIT_W    = $clog2(DATA_W + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

    spi_state_t          r_state;
    logic [DATA_W-1:0]   r_count;
    logic [DATA_W-1:0]   r_shreg;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_cs_n;
    logic                r_busy;
    logic                r_done;

    spi_state_t          w_state_nxt;
    logic [DATA_W-1:0]   w_shreg_nxt;
    logic [c_BIT_W-1:0]  w_bit_nxt;
    logic                w_sclk_nxt;
    logic                w_mosi_nxt;
    logic                w_cs_n_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_tick;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk_100),
        .rst    (s_rst),
        .i_en   (r_state != ST_IDLE),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            r_count <= '0;
        end else if (next_count_i) begin
            r_count <= r_count + DATA_W'(1);
        end
    end

    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_bit_nxt   = r_bit_cnt;
        w_sclk_nxt  = r_sclk;
        w_mosi_nxt  = r_mosi;
        w_cs_n_nxt  = r_cs_n;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // r_done marks the done cycle, where a new request is still refused.
                if (start_send_i && !r_done) begin
                    w_state_nxt = ST_SHIFT;
                    w_shreg_nxt = r_count;
                    w_bit_nxt   = '0;
                    w_sclk_nxt  = 1'b0;
                    w_mosi_nxt  = r_count[DATA_W-1];
                    w_cs_n_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        w_sclk_nxt = 1'b0;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_state_nxt = ST_HOLD;
                        end else begin
                            // Rotate rather than shift so the register stays fully used.
                            w_shreg_nxt = {r_shreg[DATA_W-2:0], r_shreg[DATA_W-1]};
                            w_mosi_nxt  = r_shreg[DATA_W-2];
                            w_bit_nxt   = r_bit_cnt + c_BIT_W'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_bit_nxt   = '0;
                    w_mosi_nxt  = 1'b0;
                    w_cs_n_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_bit_nxt   = '0;
                w_sclk_nxt  = 1'b0;
                w_mosi_nxt  = 1'b0;
                w_cs_n_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign count_o    = r_count;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign spi_cs_n_o = r_cs_n;
    assign spi_sclk_o = r_sclk;
    assign spi_mosi_o = r_mosi;

endmodule : spi_send_ctrl
`default_nettype wire

// File: tb/tb_spi_send_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_send_ctrl
// Purpose  : Randomized self-checking bench for spi_send_ctrl against a waveform model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_send_ctrl;

    localparam int DW    = 8;
    localparam int CD    = 4;
    localparam int FRAME = (2 * DW + 1) * CD;

    logic          clk_100      = 1'b0;
    logic          s_rst        = 1'b1;
    logic          next_count_i = 1'b0;
    logic          start_send_i = 1'b0;
    logic [DW-1:0] count_o;
    logic          busy_o;
    logic          done_o;
    logic          spi_cs_n_o;
    logic          spi_sclk_o;
    logic          spi_mosi_o;

    int n_tests = 0;
    int n_fail  = 0;
    int m_count = 0;

    spi_send_ctrl #(
        .DATA_W  (DW),
        .CLK_DIV (CD)
    ) dut (
        .clk_100      (clk_100),
        .s_rst        (s_rst),
        .next_count_i (next_count_i),
        .start_send_i (start_send_i),
        .count_o      (count_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .spi_cs_n_o   (spi_cs_n_o),
        .spi_sclk_o   (spi_sclk_o),
        .spi_mosi_o   (spi_mosi_o)
    );

    always #5 clk_100 = ~clk_100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, tracking the count the way a user would expect it to move.
    task automatic step();
        if (s_rst)             m_count = 0;
        else if (next_count_i) m_count = (m_count + 1) % (1 << DW);
        @(posedge clk_100);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            next_count_i = 1'b1;
            step();
        end
        next_count_i = 1'b0;
    endtask

    function automatic logic [4:0] obs();
        return {spi_cs_n_o, spi_sclk_o, spi_mosi_o, busy_o, done_o};
    endfunction

    // Expected {cs_n, sclk, mosi, busy, done} k cycles after the accepting edge.
    function automatic logic [4:0] exp_sig(input logic [DW-1:0] d, input int k);
        int b;
        if (k < 2 * DW * CD) begin
            b = k / (2 * CD);
            return {1'b0, ((k % (2 * CD)) >= CD), d[DW-1-b], 1'b1, 1'b0};
        end else if (k < FRAME) begin
            return {1'b0, 1'b0, d[0], 1'b1, 1'b0};
        end
        return 5'b10001;
    endfunction

    task automatic run_frame(input bit noisy, input bit with_next, input int rst_at);
        logic [DW-1:0] d;
        int            rises;
        int            low;
        logic          prev_sclk;
        rises     = 0;
        low       = 0;
        prev_sclk = 1'b0;
        d         = DW'(m_count);
        start_send_i = 1'b1;
        next_count_i = with_next;
        step();
        start_send_i = 1'b0;
        next_count_i = 1'b0;
        for (int k = 0; k <= FRAME; k++) begin
            if (k == rst_at) begin
                s_rst        = 1'b1;
                next_count_i = 1'b1;
                start_send_i = 1'b1;
                step();
                s_rst        = 1'b0;
                next_count_i = 1'b0;
                start_send_i = 1'b0;
                chk("rst_outputs", obs(), 5'b10000);
                chk("rst_count", count_o, 0);
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk("rst_stays_idle", obs(), 5'b10000);
                end
                return;
            end
            chk($sformatf("frame_d%02h_k%0d", d, k), obs(), exp_sig(d, k));
            if (spi_sclk_o && !prev_sclk) rises++;
            prev_sclk = spi_sclk_o;
            if (!spi_cs_n_o) low++;
            if (k == FRAME) begin
                start_send_i = 1'b1;
            end else if (noisy) begin
                next_count_i = ($urandom_range(3) == 0);
                start_send_i = ($urandom_range(7) == 0);
            end
            step();
            next_count_i = 1'b0;
            start_send_i = 1'b0;
        end
        chk("sclk_rises", rises, DW);
        chk("cs_low_cycles", low, FRAME);
        chk("no_retrigger", obs(), 5'b10000);
        step();
        chk("no_retrigger2", obs(), 5'b10000);
        chk("count_after_frame", count_o, m_count);
    endtask

    // MOSI may only move on edges that leave SCLK low.
    logic mon_prev_mosi = 1'b0;
    always begin
        @(posedge clk_100);
        #1;
        if (spi_mosi_o !== mon_prev_mosi) chk("mosi_change_sclk_low", spi_sclk_o, 0);
        mon_prev_mosi = spi_mosi_o;
    end

    initial begin
        s_rst = 1'b1;
        repeat (3) step();
        s_rst = 1'b0;
        chk("reset_outputs", obs(), 5'b10000);
        chk("reset_count", count_o, 0);

        pulses(3);
        chk("count_three", count_o, 3);
        run_frame(1'b0, 1'b0, -1);

        pulses((255 - m_count) & 255);
        chk("count_ff", count_o, 8'hFF);
        pulses(1);
        chk("count_wrap", count_o, 8'h00);

        pulses(16);
        chk("count_10", count_o, 8'h10);
        run_frame(1'b0, 1'b1, -1);
        chk("simul_count", count_o, 8'h11);

        repeat (6) begin
            pulses($urandom_range(40));
            run_frame(1'b1, 1'b0, -1);
        end

        pulses(5);
        run_frame(1'b0, 1'b0, 20);

        pulses(2);
        run_frame(1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_send_ctrl
`default_nettype wire
